instr_issuer: RTL
=================

// Module: instr_issuer
// PURPOSE
//  Producer end of the controller instruction interface. Buffers a host-loaded
//  program in an instruction FIFO, then writes instructions into the controller's
//  decoder (instr_valid/instr) under credit flow control, and drives start so the
//  controller chains weight/ifmap fetch and conv. Sits between host config port and controller.
// PARAMETERS
//  FIFO_DEPTH  16  program FIFO entries (power of 2, >=2)
//  DEC_DEPTH   4   decoder slots = initial credits (>=1)
//  CNT_W       16  width of issued_cnt
// PORTS
//  clk          in   1           clock, all state on posedge
//  rst          in   1           asynchronous, active-low reset
//  prog_valid   in   1           host instruction valid
//  prog_ready   out  1           FIFO not full
//  prog_instr   in   INSTR_SIZE  host instruction; bit INSTR_SIZE-1 = LAST flag
//  go           in   1           pulse: begin issuing buffered program
//  rd_nxt_inst  in   1           decoder consumed one entry -> return one credit
//  ready        in   1           controller idle
//  instr_valid  out  1           one-cycle decoder write strobe
//  instr        out  INSTR_SIZE  instruction, valid with instr_valid
//  start        out  1           job request to controller
//  busy         out  1           state != IDLE
//  done         out  1           one-cycle pulse at job end
//  credit_err   out  1           sticky: rd_nxt_inst with credits==DEC_DEPTH
//  issued_cnt   out  CNT_W       instructions issued since reset, wraps
// BEHAVIOUR
//  Reset: FIFO empty, credits=DEC_DEPTH, state IDLE; instr_valid/start/busy/done/
//   credit_err=0, instr=0, issued_cnt=0; prog_ready=1 from the first cycle after reset release.
//  FIFO: push on prog_valid&prog_ready in any state; prog_ready=!full; push+pop same
//   cycle when full is not allowed (ready already low); push+pop when empty: no bypass.
//  Credits: -1 on issue, +1 on rd_nxt_inst, both same cycle -> unchanged. rd_nxt_inst
//   at DEC_DEPTH ignored and sets credit_err.
//  States:
//   IDLE  : go & !empty -> ISSUE; go & empty -> stay, done=1 next cycle.
//   ISSUE : issue when !empty & credits>0: pop, register instr, instr_valid=1 next cycle
//           (1-cycle latency, back-to-back allowed). Issued LAST -> DRAIN. Empty & no
//           LAST -> hold in ISSUE (wait for host).
//   DRAIN : no issue; wait credits==DEC_DEPTH, then start drops; next cycle with
//           ready=1 -> done pulse, IDLE.
//  start: set the cycle instr_valid first rises in a job; held through ISSUE and DRAIN
//   until credits==DEC_DEPTH; never high in IDLE.
//  go outside IDLE ignored. Entries behind LAST stay in FIFO for next go.
//  Reset mid-job: immediate return to reset values; FIFO contents discarded.
// STRUCTURE
//  Config package: INSTR_SIZE (existing), LAST_BIT localparam, issuer_state_e enum.
//  Sub-module: instr_fifo (sync FIFO, full/empty, count) - reusable for decoder side.
// TESTING
//  1 load 3 instr (last on #3), go -> instr_valid 3 consecutive cycles, start high from
//    first strobe, issued_cnt=3, state DRAIN.
//  2 DEC_DEPTH=4, load 6, no rd_nxt_inst -> exactly 4 strobes then stall; 2 rd_nxt_inst
//    pulses -> 2 more strobes; returning all credits + ready=1 -> start=0, done pulse.
//  3 fill FIFO to 16 -> prog_ready=0; 17th push dropped; go drains all in order (data match).
//  4 rd_nxt_inst with credits=4 -> credit_err=1 sticky, credits stay 4.
//  5 go with empty FIFO -> done pulse next cycle, start never asserted.
//  6 rst low during ISSUE after 2 strobes -> all outputs 0 asynchronously, FIFO empty,
//    credits=4 after release.

Source files
------------

// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer and its program FIFO.
//   INSTR_SIZE     : width of one controller instruction
//   LAST_BIT       : bit that marks the final instruction of a job
//   issuer_state_e : issuer job state
//   is_last()      : tests the LAST flag of an instruction word
package instr_issuer_pkg;

  localparam int INSTR_SIZE = 32;
  localparam int LAST_BIT   = INSTR_SIZE - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } issuer_state_e;

  function automatic logic is_last(input logic [INSTR_SIZE-1:0] word);
    return word[LAST_BIT];
  endfunction

endpackage

// File: rtl/instr_issuer_fifo.sv
// Synchronous FIFO that holds instruction words. It has full, empty and count flags,
// and it is written generically so that it can also serve on the decoder side.
//   clk, rst     : clock and asynchronous active-low reset (pointers and count only)
//   push/wr_data : write request. It is ignored when the FIFO is full.
//   pop/rd_data  : read request. It is ignored when the FIFO is empty. rd_data shows the head entry.
//   full/empty   : occupancy flags
//   count        : number of stored entries
module instr_fifo
  import instr_issuer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = INSTR_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  // An empty FIFO cannot pop. For this reason a word written while the FIFO is empty is never bypassed.
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The storage array has no reset. The reset pointers already mark every entry as stale.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_issuer.sv
// Producer end of the controller instruction interface. A program loaded by the host
// is buffered in a FIFO. After go, the issuer writes the program into the controller's
// decoder under credit flow control and holds start for the duration of the job.
//   clk, rst          : clock and asynchronous active-low reset
//   prog_valid/ready  : host load handshake (ready = FIFO not full)
//   prog_instr        : host instruction. The top bit is the LAST flag.
//   go                : pulse that starts issuing the buffered program. It is honoured only in IDLE.
//   rd_nxt_inst       : the decoder freed one slot, so one credit returns
//   ready             : the controller is idle
//   instr_valid/instr : one-cycle decoder write strobe and its instruction
//   start             : job request to the controller
//   busy              : the issuer is not idle
//   done              : one-cycle pulse at the end of a job
//   credit_err        : sticky flag. A credit was returned while all credits were already home.
//   issued_cnt        : number of instructions issued since reset. The count wraps.
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DEC_DEPTH  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_valid,
  output logic                  prog_ready,
  input  logic [INSTR_SIZE-1:0] prog_instr,
  input  logic                  go,
  input  logic                  rd_nxt_inst,
  input  logic                  ready,
  output logic                  instr_valid,
  output logic [INSTR_SIZE-1:0] instr,
  output logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  credit_err,
  output logic [CNT_W-1:0]      issued_cnt
);

  localparam int              CR_W    = $clog2(DEC_DEPTH + 1);
  localparam logic [CR_W-1:0] CR_FULL = CR_W'(DEC_DEPTH);

  issuer_state_e                 state;
  logic [CR_W-1:0]               credits;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [INSTR_SIZE-1:0]         fifo_head;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count_unused;
  logic                          issue;
  logic                          credit_ret;

  assign prog_ready = !fifo_full;
  assign busy       = (state != ST_IDLE);
  assign issue      = (state == ST_ISSUE) && !fifo_empty && (credits != '0);
  // A credit that returns while all credits are already home is spurious. It is dropped.
  assign credit_ret = rd_nxt_inst && (credits != CR_FULL);

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_SIZE)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (prog_valid),
    .wr_data (prog_instr),
    .pop     (issue),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      credits     <= CR_FULL;
      instr_valid <= 1'b0;
      instr       <= '0;
      start       <= 1'b0;
      done        <= 1'b0;
      credit_err  <= 1'b0;
      issued_cnt  <= '0;
    end else begin
      instr_valid <= 1'b0;
      done        <= 1'b0;

      if (rd_nxt_inst && (credits == CR_FULL)) credit_err <= 1'b1;

      case ({issue, credit_ret})
        2'b10:   credits <= credits - CR_W'(1);
        2'b01:   credits <= credits + CR_W'(1);
        default: credits <= credits;
      endcase

      // Issue stage: the popped head is registered onto the decoder write port.
      if (issue) begin
        instr       <= fifo_head;
        instr_valid <= 1'b1;
        issued_cnt  <= issued_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (go) begin
            if (!fifo_empty) state <= ST_ISSUE;
            else             done  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // start rises together with the first strobe of the job.
          if (issue) begin
            start <= 1'b1;
            if (is_last(fifo_head)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // First phase: wait until the decoder returns every slot, then drop start.
          // Second phase: start is already low, so wait for the controller to go idle.
          if (start) begin
            if (credits == CR_FULL) start <= 1'b0;
          end else if (ready) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
